// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : ex_muldiv_unit
// Brief   : Iterative EX-stage multiply/divide unit owning the HI/LO registers.
// Revision: 1.0  initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_MD_Start,
  input  logic [1:0]       EX_MD_Op,
  input  logic             EX_MtHi,
  input  logic             EX_MtLo,
  input  logic             EX_MfHi,
  input  logic             EX_MfLo,
  input  logic [WIDTH-1:0] EX_Read_data1,
  input  logic [WIDTH-1:0] EX_Read_data2,
  output logic             MD_Busy,
  output logic             MD_Done,
  output logic             MD_Stall,
  output logic [WIDTH-1:0] MD_Result,
  output logic [WIDTH-1:0] MD_HI,
  output logic [WIDTH-1:0] MD_LO
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] acc;          // partial product high half / remainder
  logic [WIDTH-1:0] shreg;        // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] operand_b;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] dividend_raw;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div_zero;
  logic             done_reg;

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shifted;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand magnitudes; unsigned ops pass raw values through
  always_comb begin
    op_signed = ~EX_MD_Op[0];
    a_neg     = op_signed & EX_Read_data1[WIDTH-1];
    b_neg     = op_signed & EX_Read_data2[WIDTH-1];
    a_mag     = a_neg ? (~EX_Read_data1 + 1'b1) : EX_Read_data1;
    b_mag     = b_neg ? (~EX_Read_data2 + 1'b1) : EX_Read_data2;
  end

  // One iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
    div_shifted = {acc, shreg[WIDTH-1]};
    div_ge      = div_shifted >= {1'b0, operand_b};
    div_diff    = div_shifted[WIDTH-1:0] - operand_b;
    if (is_div) begin
      acc_next   = div_ge ? div_diff : div_shifted[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], div_ge};
    end else begin
      acc_next   = mul_sum[WIDTH:1];
      shreg_next = {mul_sum[0], shreg[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIXUP
  always_comb begin
    prod       = {acc, shreg};
    prod_fixed = neg_lo ? (~prod + 1'b1) : prod;
    if (!is_div) begin
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
      fix_lo = prod_fixed[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = dividend_raw;
      fix_lo = {WIDTH{1'b1}};
    end else begin
      fix_hi = neg_hi ? (~acc + 1'b1) : acc;
      fix_lo = neg_lo ? (~shreg + 1'b1) : shreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (EX_MD_Start) state_next = RUN;
      RUN:     if (count == LAST) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      acc          <= '0;
      shreg        <= '0;
      operand_b    <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      div_zero     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state == FIXUP);
      case (state)
        IDLE: begin
          if (EX_MD_Start) begin
            count        <= '0;
            acc          <= '0;
            is_div       <= EX_MD_Op[1];
            dividend_raw <= EX_Read_data1;
            neg_lo       <= a_neg ^ b_neg;
            neg_hi       <= a_neg;
            div_zero     <= EX_MD_Op[1] & (EX_Read_data2 == '0);
            // Multiply shifts the multiplier out; divide shifts the dividend out
            shreg        <= EX_MD_Op[1] ? a_mag : b_mag;
            operand_b    <= EX_MD_Op[1] ? b_mag : a_mag;
          end else begin
            if (EX_MtHi) hi_reg <= EX_Read_data1;
            if (EX_MtLo) lo_reg <= EX_Read_data1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          shreg <= shreg_next;
          count <= count + CW'(1);
        end
        FIXUP: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    MD_Busy   = (state != IDLE);
    MD_Done   = done_reg;
    MD_Stall  = MD_Busy & (EX_MD_Start | EX_MfHi | EX_MfLo | EX_MtHi | EX_MtLo);
    MD_Result = EX_MfHi ? hi_reg : lo_reg;
    MD_HI     = hi_reg;
    MD_LO     = lo_reg;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// Testbench for ex_muldiv_unit: directed + random ops, scoreboard on MD_Done.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_s = 2'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        mfhi = 1'b0;
  logic        mflo = 1'b0;
  logic [31:0] d1 = 32'd0;
  logic [31:0] d2 = 32'd0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .EX_MD_Start(start), .EX_MD_Op(op_s),
    .EX_MtHi(mthi), .EX_MtLo(mtlo), .EX_MfHi(mfhi), .EX_MfLo(mflo),
    .EX_Read_data1(d1), .EX_Read_data2(d2),
    .MD_Busy(busy), .MD_Done(done), .MD_Stall(stall),
    .MD_Result(result), .MD_HI(hi), .MD_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: returns {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = 64'd0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Scoreboard monitor: every Done pops one expected {HI,LO}
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected: got done=1 expected no pending op");
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_hi", hi, e[63:32]);
        check("sb_lo", lo, e[31:0]);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input logic mt_with_start);
    logic [31:0] old_hi, old_lo;
    int cyc;
    @(negedge clk);
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; op_s = op; d1 = a; d2 = b; mthi = mt_with_start;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; d1 = $urandom; d2 = $urandom;
    cyc = 1;
    while (busy && cyc < 100) begin
      if (cyc == 2) mtlo = 1'b1;
      if (cyc == 3) begin
        mtlo = 1'b0;
        check("hi_held_midop", hi, old_hi);
        check("lo_held_midop", lo, old_lo);
      end
      @(negedge clk);
      cyc++;
    end
    check("busy_cycles", 32'(cyc - 1), 32'd33);
    check("done_set", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [63:0] e;
    logic saw_done;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_op(2'd3, 32'h0000_0007, 32'h0000_0002, {32'h0000_0001, 32'h0000_0003}, 1'b0);
    run_op(2'd3, 32'h1234_5678, 32'h0000_0000, {32'h1234_5678, 32'hFFFF_FFFF}, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);
    run_op(2'd2, 32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, model(rop, ra, rb), 1'($urandom_range(0, 1)));
    end

    // mfhi held while busy stalls; a second Start during busy is ignored
    ra = $urandom;
    rb = $urandom;
    e  = model(2'd1, ra, rb);
    @(negedge clk);
    start = 1'b1; op_s = 2'd1; d1 = ra; d2 = rb;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 100) begin
      if (cyc == 5) mfhi = 1'b1;
      if (cyc == 10) begin start = 1'b1; op_s = 2'd3; d1 = $urandom; d2 = $urandom; end
      if (cyc == 11) start = 1'b0;
      #1;
      check("stall_busy", {31'd0, stall}, {31'd0, (cyc >= 5)});
      @(negedge clk);
      cyc++;
    end
    check("stall_busy_cycles", 32'(cyc - 1), 32'd33);
    #1;
    check("stall_released", {31'd0, stall}, 32'd0);
    check("mfhi_new_hi", result, e[63:32]);
    mfhi = 1'b0;
    mflo = 1'b1;
    #1;
    check("mflo_new_lo", result, e[31:0]);
    mflo = 1'b0;
    @(negedge clk);

    // Reset mid-operation at count=10
    @(negedge clk);
    start = 1'b1; op_s = 2'd1; d1 = 32'hFFFF_FFFF; d2 = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    // mtlo / mthi while idle
    mtlo = 1'b1; d1 = 32'hAAAA_5555;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hAAAA_5555);
    check("mtlo_hi_untouched", hi, 32'd0);
    mthi = 1'b1; d1 = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo_untouched", lo, 32'hAAAA_5555);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
